athena_video_conditioner: RTL and testbench

Sits directly downstream of the Athena core's raw video outputs and upstream of the Pocket video interface, all in the 53.6 MHz core clock domain. It samples R/G/B, blanks and syncs only on CE_PIXEL cycles. It produces registered per-pixel RGB888, data-enable and single-cycle hs/vs pulses. It also measures active frame geometry (width, height) and raises a lock flag once the geometry is stable across frames.

---
 rtl/athena_video_conditioner.sv | 145 ++++++++++++++
 tb/tb_athena_video_conditioner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/athena_video_conditioner.sv
// Conditions raw Athena core video into registered RGB888 with data enable and sync pulses,
// and measures active frame geometry with a stability lock.
module athena_video_conditioner #(
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned HCNT_WIDTH = 10,
  parameter int unsigned VCNT_WIDTH = 9,
  parameter int unsigned HS_DELAY   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_pixel,
  input  logic [COLOR_BITS-1:0] r,
  input  logic [COLOR_BITS-1:0] g,
  input  logic [COLOR_BITS-1:0] b,
  input  logic                  hblank,
  input  logic                  vblank,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic                  pix_valid,
  output logic                  de,
  output logic [23:0]           rgb,
  output logic                  hs,
  output logic                  vs,
  output logic [HCNT_WIDTH-1:0] x,
  output logic [VCNT_WIDTH-1:0] y,
  output logic [HCNT_WIDTH-1:0] active_width,
  output logic [VCNT_WIDTH-1:0] active_height,
  output logic                  geometry_locked
);

  // Replicate each channel enough times to cover 8 bits, then keep the top byte.
  localparam int unsigned ColorReps = (8 + COLOR_BITS - 1) / COLOR_BITS;
  localparam int unsigned RepW      = COLOR_BITS * ColorReps;

  logic [RepW-1:0] r_rep, g_rep, b_rep;
  logic [23:0]     rgb_exp;

  assign r_rep   = {ColorReps{r}};
  assign g_rep   = {ColorReps{g}};
  assign b_rep   = {ColorReps{b}};
  assign rgb_exp = {r_rep[RepW-1 -: 8], g_rep[RepW-1 -: 8], b_rep[RepW-1 -: 8]};

  logic                  pix_valid_q, de_q, hs_q, vs_q, locked_q;
  logic [23:0]           rgb_q;
  logic [HCNT_WIDTH-1:0] x_q, x_cnt_q, active_width_q, prev_w_q;
  logic [VCNT_WIDTH-1:0] y_q, y_cnt_q, active_height_q, prev_h_q;
  logic                  hsync_prev_q, vsync_prev_q, vblank_prev_q;

  logic                  de_next, hs_rise, vs_rise, vb_rise, eol, hs_exit;
  logic [HCNT_WIDTH-1:0] x_inc, width_now;
  logic [VCNT_WIDTH-1:0] y_inc, height_now;

  always_comb begin
    de_next    = ~(hblank | vblank);
    hs_rise    = hsync & ~hsync_prev_q;
    vs_rise    = vsync & ~vsync_prev_q;
    vb_rise    = vblank & ~vblank_prev_q;
    // de_q holds the previous ce-sample of de, so this is the active-to-blank transition.
    eol        = de_q & ~de_next;
    x_inc      = (x_cnt_q == '1) ? x_cnt_q : x_cnt_q + 1'b1;
    y_inc      = (y_cnt_q == '1) ? y_cnt_q : y_cnt_q + 1'b1;
    // A line ending on the same ce as the vblank rise is counted before the frame closes.
    width_now  = eol ? x_cnt_q : active_width_q;
    height_now = eol ? y_inc : y_cnt_q;
  end

  if (HS_DELAY == 0) begin : g_hs_nodelay
    assign hs_exit = hs_rise;
  end else begin : g_hs_delay
    logic [HS_DELAY-1:0] hs_dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_dly_q <= '0;
      end else if (ce_pixel) begin
        hs_dly_q <= (hs_dly_q << 1) | HS_DELAY'(hs_rise);
      end
    end

    assign hs_exit = hs_dly_q[HS_DELAY-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q     <= 1'b0;
      de_q            <= 1'b0;
      rgb_q           <= '0;
      hs_q            <= 1'b0;
      vs_q            <= 1'b0;
      x_q             <= '0;
      y_q             <= '0;
      x_cnt_q         <= '0;
      y_cnt_q         <= '0;
      active_width_q  <= '0;
      active_height_q <= '0;
      prev_w_q        <= '0;
      prev_h_q        <= '0;
      locked_q        <= 1'b0;
      hsync_prev_q    <= 1'b0;
      vsync_prev_q    <= 1'b0;
      vblank_prev_q   <= 1'b0;
    end else begin
      pix_valid_q <= ce_pixel;
      hs_q        <= ce_pixel & hs_exit;
      vs_q        <= ce_pixel & vs_rise;
      if (ce_pixel) begin
        hsync_prev_q  <= hsync;
        vsync_prev_q  <= vsync;
        vblank_prev_q <= vblank;
        de_q          <= de_next;
        rgb_q         <= de_next ? rgb_exp : '0;
        x_q           <= de_next ? x_cnt_q : '0;
        x_cnt_q       <= de_next ? x_inc : '0;
        y_q           <= vblank ? '0 : y_cnt_q;
        if (vblank) begin
          y_cnt_q <= '0;
        end else if (eol) begin
          y_cnt_q <= y_inc;
        end
        if (eol) begin
          active_width_q <= x_cnt_q;
        end
        if (vb_rise) begin
          active_height_q <= height_now;
          locked_q        <= (prev_w_q == width_now) && (prev_h_q == height_now) &&
                             (width_now != '0) && (height_now != '0);
          prev_w_q        <= width_now;
          prev_h_q        <= height_now;
        end
      end
    end
  end

  assign pix_valid       = pix_valid_q;
  assign de              = de_q;
  assign rgb             = rgb_q;
  assign hs              = hs_q;
  assign vs              = vs_q;
  assign x               = x_q;
  assign y               = y_q;
  assign active_width    = active_width_q;
  assign active_height   = active_height_q;
  assign geometry_locked = locked_q;

endmodule

// File: tb/tb_athena_video_conditioner.sv
// Scoreboard bench for athena_video_conditioner: HS_DELAY=2 and HS_DELAY=0 instances share stimulus.
module tb_athena_video_conditioner;

  localparam int HBL = 8;
  localparam int VBL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, ce_pixel;
  logic [3:0] r, g, b;
  logic       hblank, vblank, hsync, vsync;

  logic        pix_valid, de, hs, vs, geometry_locked;
  logic [23:0] rgb;
  logic [9:0]  x, active_width;
  logic [8:0]  y, active_height;

  logic        pix_valid_0, de_0, hs_0, vs_0, geometry_locked_0;
  logic [23:0] rgb_0;
  logic [9:0]  x_0, active_width_0;
  logic [8:0]  y_0, active_height_0;

  athena_video_conditioner #(.HS_DELAY(2)) dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .r(r), .g(g), .b(b),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .pix_valid(pix_valid), .de(de), .rgb(rgb), .hs(hs), .vs(vs), .x(x), .y(y),
    .active_width(active_width), .active_height(active_height),
    .geometry_locked(geometry_locked)
  );

  athena_video_conditioner #(.HS_DELAY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .r(r), .g(g), .b(b),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .pix_valid(pix_valid_0), .de(de_0), .rgb(rgb_0), .hs(hs_0), .vs(vs_0), .x(x_0), .y(y_0),
    .active_width(active_width_0), .active_height(active_height_0),
    .geometry_locked(geometry_locked_0)
  );

  typedef struct packed {
    logic        pv;
    logic        de;
    logic [23:0] rgb;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        hs2;
    logic        hs0;
    logic        vs;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one clock of stimulus, queue its expected outputs, compare after the edge.
  task automatic cyc(input bit ce, input logic [3:0] rr, input logic [3:0] gg,
                     input logic [3:0] bb, input bit hb, input bit vb, input bit hsy,
                     input bit vsy, input exp_t e);
    exp_t want;
    @(negedge clk);
    ce_pixel = ce;
    r = rr; g = gg; b = bb;
    hblank = hb; vblank = vb; hsync = hsy; vsync = vsy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    check("out_d2", 64'({pix_valid, de, rgb, x, (de ? y : 9'd0), hs, vs}),
          64'({want.pv, want.de, want.rgb, want.x, want.y, want.hs2, want.vs}));
    check("out_d0", 64'({pix_valid_0, de_0, rgb_0, x_0, (de_0 ? y_0 : 9'd0), hs_0, vs_0}),
          64'({want.pv, want.de, want.rgb, want.x, want.y, want.hs0, want.vs}));
    last_e = e;
  endtask

  // Non-ce clock with scrambled inputs: everything holds, pulses stay low.
  task automatic idle();
    exp_t e;
    e     = last_e;
    e.pv  = 1'b0;
    e.hs2 = 1'b0;
    e.hs0 = 1'b0;
    e.vs  = 1'b0;
    cyc(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
        1'($urandom), 1'($urandom), e);
  endtask

  task automatic frame(input int w, input int h, input int gap, input bit vb_early,
                       input bit rand_col, input bit hold5);
    exp_t       e;
    logic [3:0] rr, gg, bb;
    bit         hb, vb, hsy, vsy, act;
    int         j, v;
    for (int ln = 0; ln < h + VBL; ln++) begin
      for (int col = 0; col < w + HBL; col++) begin
        j   = col - w;
        v   = ln - h;
        hb  = (col >= w);
        vb  = (ln >= h) || (vb_early && ln == h - 1 && hb);
        hsy = hb && j >= 2 && j < 6;
        vsy = (v == 1 && j >= 2) || (v == 2);
        act = !hb && !vb;
        if (rand_col) begin
          rr = 4'($urandom); gg = 4'($urandom); bb = 4'($urandom);
        end else begin
          rr = 4'hA; gg = 4'h5; bb = 4'hF;
        end
        e     = '0;
        e.pv  = 1'b1;
        e.de  = act;
        e.rgb = act ? {rr, rr, gg, gg, bb, bb} : 24'h0;
        e.x   = act ? 10'((col > 1023) ? 1023 : col) : 10'd0;
        e.y   = act ? 9'(ln) : 9'd0;
        e.hs0 = hb && j == 2;
        e.hs2 = hb && j == 4;
        e.vs  = (v == 1 && j == 2);
        cyc(1'b1, rr, gg, bb, hb, vb, hsy, vsy, e);
        repeat ((hold5 && ln == 1 && col == 10) ? 5 : gap) idle();
      end
    end
  endtask

  task automatic geo(input string tag, input int aw, input int ah, input bit lk);
    check(tag, 64'({active_width, active_height, geometry_locked}),
          64'({10'(aw), 9'(ah), lk}));
    check({tag, "_d0"}, 64'({active_width_0, active_height_0, geometry_locked_0}),
          64'({10'(aw), 9'(ah), lk}));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pix"}, 64'({pix_valid, de, rgb, hs, vs, x, y}), 64'(0));
    check({tag, "_pix_d0"}, 64'({pix_valid_0, de_0, rgb_0, hs_0, vs_0, x_0, y_0}), 64'(0));
    geo({tag, "_geo"}, 0, 0, 1'b0);
  endtask

  initial begin
    exp_t e;
    reset_n  = 1'b0;
    ce_pixel = 1'b0;
    r = '0; g = '0; b = '0;
    hblank = 1'b0; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
    last_e = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_init");
    @(negedge clk);
    reset_n = 1'b1;

    // Wide line: x and active_width saturate at 1023.
    frame(1100, 2, 0, 1'b0, 1'b1, 1'b0);
    geo("geo_sat", 1023, 2, 1'b0);

    frame(304, 8, 1, 1'b0, 1'b0, 1'b0);
    geo("geo_f1", 304, 8, 1'b0);
    frame(304, 8, 1, 1'b0, 1'b1, 1'b0);
    geo("geo_f2", 304, 8, 1'b1);
    frame(304, 7, 1, 1'b0, 1'b1, 1'b1);
    geo("geo_f3", 304, 7, 1'b0);
    // Last line ends on the same ce as the vblank rise.
    frame(304, 7, 1, 1'b1, 1'b1, 1'b0);
    geo("geo_f4", 304, 7, 1'b1);

    // Partial line up to x=37, then asynchronous reset mid-cycle.
    for (int col = 0; col < 38; col++) begin
      e     = '0;
      e.pv  = 1'b1;
      e.de  = 1'b1;
      e.rgb = 24'h33CC66;
      e.x   = 10'(col);
      cyc(1'b1, 4'h3, 4'hC, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, e);
      idle();
    end
    check("x_at_37", 64'(x), 64'(37));
    #2;
    reset_n = 1'b0;
    #1;
    check_reset("rst_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    last_e  = '0;

    frame(20, 3, 1, 1'b0, 1'b1, 1'b0);
    geo("geo_after_rst", 20, 3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
